// File: rtl/core2wb_pkg.sv
// Shared types and helpers for the core-to-Wishbone pipelined bridge.
//   core2wb_state_e : bridge state machine encoding
//   cnt_width()     : bits needed to hold values 0..max_val (min 1)
package core2wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StFlush
  } core2wb_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/core2wb_watchdog.sv
// Hung-cycle watchdog for core2wb_pipe.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart counting from zero (has priority over enable)
//   enable     : count this cycle
//   expired    : counter sits at TIMEOUT_CYCLES-1 while enabled and not cleared
module core2wb_watchdog
  import core2wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned WdW = cnt_width(TIMEOUT_CYCLES - 1);
  localparam logic [WdW-1:0] Limit = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != Limit)) begin
      count_d = count_q + WdW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable & ~clear & (count_q == Limit);

endmodule

// File: rtl/core2wb_pipe.sv
// Ibex req/gnt/rvalid to Wishbone B4 pipelined bridge, up to MAX_OUTSTANDING in flight.
// Optional watchdog (macro CORE2WB_PIPE_TIMEOUT_EN) aborts hung cycles and answers every
// outstanding request with an error.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   core_req/we/be/addr/wdata   core request
//   core_gnt                    request accepted this cycle
//   core_rvalid/rdata/err       response, one pulse per grant
//   wb_cyc/stb/we/adr/sel/dat_o Wishbone master outputs (adr is the word address)
//   wb_dat_i/ack/err/stall      Wishbone slave responses
//   timeout                     one-cycle pulse when an abort begins
module core2wb_pipe
  import core2wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  localparam int unsigned SEL_W          = DATA_WIDTH / 8,
  localparam int unsigned OFF_W          = $clog2(SEL_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     core_req,
  input  logic                     core_we,
  input  logic [SEL_W-1:0]         core_be,
  input  logic [ADDR_WIDTH-1:0]    core_addr,
  input  logic [DATA_WIDTH-1:0]    core_wdata,
  output logic                     core_gnt,
  output logic                     core_rvalid,
  output logic [DATA_WIDTH-1:0]    core_rdata,
  output logic                     core_err,
  output logic                     wb_cyc,
  output logic                     wb_stb,
  output logic                     wb_we,
  output logic [ADDR_WIDTH-OFF_W-1:0] wb_adr,
  output logic [SEL_W-1:0]         wb_sel,
  output logic [DATA_WIDTH-1:0]    wb_dat_o,
  input  logic [DATA_WIDTH-1:0]    wb_dat_i,
  input  logic                     wb_ack,
  input  logic                     wb_err,
  input  logic                     wb_stall,
  output logic                     timeout
);

  localparam int unsigned CntW = cnt_width(MAX_OUTSTANDING);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

  core2wb_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic not_flush, full, cnt_nz, bus_resp, issue, resp;
  logic expired, flush_resp;

  assign not_flush = (state_q != StFlush);
  assign full      = (cnt_q >= MaxCnt);
  assign cnt_nz    = (cnt_q != '0);
  assign bus_resp  = wb_ack | wb_err;

  assign wb_stb   = core_req & ~full & not_flush;
  assign issue    = wb_stb & ~wb_stall;
  // Responses with nothing outstanding are stray and dropped.
  assign resp     = bus_resp & cnt_nz & not_flush;
  assign wb_cyc   = wb_stb | (cnt_nz & not_flush);
  assign core_gnt = issue;

  assign wb_we    = core_we;
  assign wb_sel   = core_be;
  assign wb_dat_o = core_wdata;
  assign wb_adr   = core_addr[ADDR_WIDTH-1:OFF_W];

  if (OFF_W > 0) begin : g_addr_lsb
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^core_addr[OFF_W-1:0];
  end

`ifdef CORE2WB_PIPE_TIMEOUT_EN
  logic wd_clear, wd_enable;

  assign wd_clear  = bus_resp | ~cnt_nz | (state_q != StBusy);
  assign wd_enable = (state_q == StBusy) & cnt_nz;

  core2wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(expired)
  );

  // FLUSH is only entered with cnt != 0, so each FLUSH cycle retires one request.
  assign flush_resp = (state_q == StFlush);
`else
  localparam int unsigned UnusedTimeoutCycles = TIMEOUT_CYCLES;
  assign expired    = 1'b0;
  assign flush_resp = 1'b0;
`endif

  assign timeout     = expired;
  assign core_rvalid = resp | flush_resp;
  assign core_err    = (resp & wb_err) | flush_resp;
  assign core_rdata  = flush_resp ? '0 : wb_dat_i;

  always_comb begin
    state_d = state_q;
    if (flush_resp) begin
      cnt_d = cnt_q - CntW'(1);
    end else begin
      cnt_d = cnt_q + CntW'(issue) - CntW'(resp);
    end

    unique case (state_q)
      StIdle: begin
        if (issue) state_d = StBusy;
      end
      StBusy: begin
        if (expired) begin
          state_d = StFlush;
        end else if (cnt_d == '0) begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        if (cnt_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
